codeword_packer_stream: RTL and testbench

Multi-lane, parametrised successor to the current compressed-word packer.
- Each cycle it accepts up to LANES variable-length codewords and packs them LSB-first into an accumulator.
- It emits fixed OUT_W-bit beats over a valid/ready handshake.
- At end of line it zero-pads the tail and marks the final beat.
- It aborts the line when compressed size exceeds LINE_BITS, so downstream selects the raw backup line.
- It sits between the code concatenators and the compressed-line buffer.

---
 rtl/packer_pkg.sv | 29 ++
 rtl/lane_prefix_sum.sv | 27 ++
 rtl/codeword_packer_stream.sv | 185 ++++++++++++++++++
 tb/tb_codeword_packer_stream.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// packer_pkg: shared state type, sizing helpers and default geometry
// for the codeword packer stream
package packer_pkg;

  typedef enum logic [1:0] {
    PACK,
    FLUSH,
    ABORT_DRAIN,
    ABORT_OUT
  } state_e;

  localparam int DEF_LANES     = 2;
  localparam int DEF_CODE_W    = 34;
  localparam int DEF_OUT_W     = 128;
  localparam int DEF_LINE_BITS = 512;

  function automatic int len_w(input int code_w);
    return $clog2(code_w + 1);
  endfunction

  function automatic int cnt_w(
    input int line_bits,
    input int lanes,
    input int code_w
  );
    return $clog2(line_bits + lanes * code_w + 1);
  endfunction

endpackage

// File: rtl/lane_prefix_sum.sv
// lane_prefix_sum: per-lane bit offsets and total length of one input beat
// disabled lanes count as zero-length
module lane_prefix_sum #(
  parameter int LANES = 2,
  parameter int LEN_W = 6,
  parameter int CNT_W = 10
) (
  input  logic [LANES*LEN_W-1:0]        len,
  input  logic [LANES-1:0]              lane_en,
  output logic [LANES-1:0][LEN_W-1:0]   eff,
  output logic [LANES-1:0][CNT_W-1:0]   offset,
  output logic [CNT_W-1:0]              total
);

  // running sum of enabled lane lengths, lane 0 first
  always_comb begin
    total  = '0;
    eff    = '0;
    offset = '0;
    for (int k = 0; k < LANES; k++) begin
      eff[k]    = lane_en[k] ? len[k*LEN_W +: LEN_W] : '0;
      offset[k] = total;
      total     = total + CNT_W'(eff[k]);
    end
  end

endmodule

// File: rtl/codeword_packer_stream.sv
// codeword_packer_stream: packs variable-length codewords into OUT_W beats
// optional PACKER_STATS_EN adds o_line_bits (line compressed bit count)
module codeword_packer_stream
  import packer_pkg::*;
#(
  parameter  int LANES     = DEF_LANES,
  parameter  int CODE_W    = DEF_CODE_W,
  parameter  int OUT_W     = DEF_OUT_W,
  parameter  int LINE_BITS = DEF_LINE_BITS,
  localparam int LEN_W     = len_w(CODE_W),
  localparam int ACC_W     = OUT_W + LANES * CODE_W,
  localparam int CNT_W     = cnt_w(LINE_BITS, LANES, CODE_W)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*CODE_W-1:0] i_code,
  input  logic [LANES*LEN_W-1:0]  i_len,
  input  logic [LANES-1:0]        i_lane_en,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [OUT_W-1:0]        o_data,
  output logic                    o_last,
  output logic                    o_abort
`ifdef PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]        o_line_bits
`endif
);

  localparam logic [CNT_W-1:0]  OUT_C  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0]  LINE_C = CNT_W'(LINE_BITS);
  localparam logic [CNT_W-1:0]  CLIP_C = CNT_W'(LINE_BITS + 1);
  localparam logic [LEN_W-1:0]  CW_C   = LEN_W'(CODE_W);
  localparam logic [CODE_W-1:0] ONES   = '1;

  state_e                      state, state_n;
  logic [ACC_W-1:0]            acc, acc_n, ins;
  logic [CNT_W-1:0]            fill, fill_n;
  logic [CNT_W-1:0]            tot, tot_n;
  logic [CNT_W-1:0]            base, sum, total_len;
  logic [LANES-1:0][CNT_W-1:0] off;
  logic [LANES-1:0][LEN_W-1:0] eff;
  logic                        full, pop, accept;

  lane_prefix_sum #(
    .LANES (LANES),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_pfx (
    .len     (i_len),
    .lane_en (i_lane_en),
    .eff     (eff),
    .offset  (off),
    .total   (total_len)
  );

  assign full   = fill >= OUT_C;
  assign base   = (state == PACK && full && i_ready)
                ? fill - OUT_C : fill;
  assign sum    = tot + total_len;
  assign pop    = o_valid && i_ready;
  assign accept = i_valid && o_ready;

  // slot each lane's length-masked codeword after the retained bits
  always_comb begin
    ins = '0;
    for (int k = 0; k < LANES; k++) begin
      ins = ins | (ACC_W'(i_code[k*CODE_W +: CODE_W]
                 & (ONES >> (CW_C - eff[k])))
                 << (base + off[k]));
    end
  end

  // beat and handshake outputs decoded from the line state
  always_comb begin
    o_valid = 1'b0;
    o_ready = 1'b0;
    o_last  = 1'b0;
    o_abort = 1'b0;
    o_data  = acc[OUT_W-1:0];
    unique case (state)
      PACK: begin
        o_valid = full;
        o_ready = base <= OUT_C;
      end
      FLUSH: begin
        o_valid = 1'b1;
        o_last  = fill <= OUT_C;
      end
      ABORT_DRAIN: begin
        o_ready = 1'b1;
      end
      ABORT_OUT: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_abort = 1'b1;
        o_data  = '0;
      end
      default: ;
    endcase
  end

  // next line state, accumulator and counters
  always_comb begin
    state_n = state;
    acc_n   = acc;
    fill_n  = fill;
    tot_n   = tot;
    unique case (state)
      PACK: begin
        if (pop) begin
          acc_n  = acc >> OUT_W;
          fill_n = base;
        end
        if (accept) begin
          if (sum > LINE_C) begin
            acc_n   = '0;
            fill_n  = '0;
            tot_n   = CLIP_C;
            state_n = i_last ? ABORT_OUT : ABORT_DRAIN;
          end else begin
            acc_n  = acc_n | ins;
            fill_n = base + total_len;
            tot_n  = sum;
            if (i_last) state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop) begin
          if (fill <= OUT_C) begin
            acc_n   = '0;
            fill_n  = '0;
            tot_n   = '0;
            state_n = PACK;
          end else begin
            acc_n  = acc >> OUT_W;
            fill_n = fill - OUT_C;
          end
        end
      end
      ABORT_DRAIN: begin
        if (accept && i_last) state_n = ABORT_OUT;
      end
      ABORT_OUT: begin
        if (pop) begin
          tot_n   = '0;
          state_n = PACK;
        end
      end
      default: ;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= PACK;
      acc   <= '0;
      fill  <= '0;
      tot   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      fill  <= fill_n;
      tot   <= tot_n;
    end
  end

`ifdef PACKER_STATS_EN
  assign o_line_bits = tot;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_len_chk
    a_len : assert property (
      @(posedge i_clk) disable iff (i_reset)
      (i_valid && o_ready && i_lane_en[k])
        |-> (i_len[k*LEN_W +: LEN_W] <= CW_C)
    );
  end

endmodule

// File: tb/tb_codeword_packer_stream.sv
// tb_codeword_packer_stream: random and directed stimulus for the packer
// checked against a bit-queue line model
module tb_codeword_packer_stream;

  localparam int LANES     = 2;
  localparam int CODE_W    = 34;
  localparam int OUT_W     = 128;
  localparam int LINE_BITS = 512;
  localparam int LEN_W     = $clog2(CODE_W + 1);
  localparam int CNT_W     = $clog2(LINE_BITS + LANES*CODE_W + 1);
  localparam int BUDGET    = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_last = 1'b0;
  logic i_ready = 1'b0;
  logic [LANES*CODE_W-1:0] i_code = '0;
  logic [LANES*LEN_W-1:0]  i_len = '0;
  logic [LANES-1:0]        i_lane_en = '0;
  logic o_ready, o_valid, o_last, o_abort;
  logic [OUT_W-1:0] o_data;
`ifdef PACKER_STATS_EN
  logic [CNT_W-1:0] line_bits;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 1;

  bit q[$];
  bit ended = 0;
  bit ab = 0;
  int lbits = 0;

  logic [OUT_W-1:0] lg_data[$];
  bit lg_last[$];
  bit lg_abort[$];

  always #5 clk = ~clk;

  codeword_packer_stream #(
    .LANES     (LANES),
    .CODE_W    (CODE_W),
    .OUT_W     (OUT_W),
    .LINE_BITS (LINE_BITS)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_code    (i_code),
    .i_len     (i_len),
    .i_lane_en (i_lane_en),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_abort   (o_abort)
`ifdef PACKER_STATS_EN
    ,
    .o_line_bits (line_bits)
`endif
  );

  task automatic chk(input string nm,
                     input logic [OUT_W-1:0] act,
                     input logic [OUT_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // downstream ready: random, forced high, or forced low
  initial forever begin
    @(negedge clk);
    #1;
    if (rdy_mode == 1) i_ready = 1'b1;
    else if (rdy_mode == 2) i_ready = 1'b0;
    else i_ready = ($urandom_range(0, 3) != 0);
  end

  // line model and per-cycle comparison, sampled just before each edge
  initial begin
    bit hold, pop, exp_v, exp_r, el;
    logic [OUT_W-1:0] hd, ed;
    logic hl, ha;
    int n, rem, ln;
    hold = 0;
    hd = '0; hl = 0; ha = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        q.delete(); ended = 0; ab = 0; lbits = 0; hold = 0;
      end else begin
        exp_v = ab ? ended : (ended || q.size() >= OUT_W);
        chk("o_valid", o_valid, exp_v);
        pop = o_valid && i_ready;
        if (ended) exp_r = 0;
        else if (ab) exp_r = 1;
        else begin
          rem = q.size() - (pop ? OUT_W : 0);
          exp_r = (rem <= OUT_W);
        end
        chk("o_ready", o_ready, exp_r);
        if (hold && o_valid) begin
          chk("hold_data", o_data, hd);
          chk("hold_last", o_last, hl);
          chk("hold_abort", o_abort, ha);
        end
        hold = o_valid && !i_ready;
        hd = o_data; hl = o_last; ha = o_abort;
        if (pop) begin
          ed = '0;
          if (ab) el = 1;
          else begin
            n = (q.size() < OUT_W) ? q.size() : OUT_W;
            el = ended && (q.size() <= OUT_W);
            for (int i = 0; i < n; i++) ed[i] = q.pop_front();
          end
          chk("beat_data", o_data, ed);
          chk("beat_last", o_last, el);
          chk("beat_abort", o_abort, ab);
`ifdef PACKER_STATS_EN
          if (el) chk("line_bits", line_bits, ab ? LINE_BITS + 1 : lbits);
`endif
          lg_data.push_back(o_data);
          lg_last.push_back(o_last);
          lg_abort.push_back(o_abort);
          if (el) begin
            q.delete(); ended = 0; ab = 0; lbits = 0;
          end
        end
        if (i_valid && o_ready) begin
          if (ab) begin
            if (i_last) ended = 1;
          end else begin
            for (int k = 0; k < LANES; k++) begin
              if (i_lane_en[k]) begin
                ln = int'(i_len[k*LEN_W +: LEN_W]);
                for (int b = 0; b < ln; b++)
                  q.push_back(i_code[k*CODE_W + b]);
                lbits += ln;
              end
            end
            if (lbits > LINE_BITS) begin
              ab = 1;
              q.delete();
            end
            if (i_last) ended = 1;
          end
        end
      end
    end
  end

  // offer one input beat and hold it until accepted; call at a negedge
  task automatic send(input logic [LANES*CODE_W-1:0] code,
                      input logic [LANES*LEN_W-1:0] len,
                      input logic [LANES-1:0] en,
                      input logic last,
                      input int gap);
    bit taken;
    repeat (gap) @(negedge clk);
    i_valid = 1'b1;
    i_code = code;
    i_len = len;
    i_lane_en = en;
    i_last = last;
    for (int c = 0; ; c++) begin
      #4;
      taken = o_ready;
      @(negedge clk);
      if (taken) break;
      if (c >= BUDGET) begin
        n_chk++;
        $display("FAIL accept_timeout: beat not taken after %0d cycles", c);
        break;
      end
    end
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (!(q.size() == 0 && !ended && !ab) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (c < 3000) n_pass++;
    else $display("FAIL %s: line not drained, %0d bits left", nm, q.size());
  endtask

  function automatic logic [LANES*CODE_W-1:0] rcode();
    logic [LANES*CODE_W-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[k*CODE_W +: CODE_W] = CODE_W'({$urandom, $urandom});
    return r;
  endfunction

  localparam logic [LANES*LEN_W-1:0] L68 = {6'd34, 6'd34};
  localparam logic [LANES*LEN_W-1:0] L64 = {6'd32, 6'd32};

  initial begin
    int b0, nb;
    logic [LANES*CODE_W-1:0] c;
    logic [LANES*LEN_W-1:0] l;
    logic [LANES-1:0] e;

    // reset held two cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_data", o_data, 0);
    @(negedge clk);

    // four 32-bit beats make exactly one final beat
    b0 = lg_data.size();
    for (int i = 0; i < 4; i++)
      send({34'h5555, 34'hAAAA}, {6'd16, 6'd16}, 2'b11, i == 3, 0);
    wait_idle("t2");
    chk("t2_count", lg_data.size() - b0, 1);
    chk("t2_data", lg_data[b0], {4{32'h5555AAAA}});
    chk("t2_last", lg_last[b0], 1);

    // full-width lane plus a masked 3-bit lane
    b0 = lg_data.size();
    send({34'h3_FFFF_FFFD, 34'h3_FFFF_FFFF}, {6'd3, 6'd34}, 2'b11, 1, 0);
    wait_idle("t3");
    chk("t3_count", lg_data.size() - b0, 1);
    chk("t3_data", lg_data[b0], 128'h17_FFFF_FFFF);
    chk("t3_last", lg_last[b0], 1);

    // all-zero lengths give a single zero final beat
    b0 = lg_data.size();
    send(rcode(), {6'd0, 6'd0}, 2'b11, 1, 0);
    wait_idle("zero");
    chk("zero_count", lg_data.size() - b0, 1);
    chk("zero_data", lg_data[b0], 0);
    chk("zero_last", lg_last[b0], 1);

    // backpressure: third 68-bit beat must stall until ready returns
    rdy_mode = 2;
    send(rcode(), L68, 2'b11, 0, 0);
    send(rcode(), L68, 2'b11, 0, 0);
    fork
      send(rcode(), L68, 2'b11, 0, 0);
      begin
        repeat (3) @(negedge clk);
        #4;
        chk("bp_ready", o_ready, 0);
        chk("bp_valid", o_valid, 1);
        rdy_mode = 1;
      end
    join
    rdy_mode = 0;
    send(rcode(), L68, 2'b11, 1, 0);
    wait_idle("t4");

    // pop and accept together at fill 130
    b0 = lg_data.size();
    rdy_mode = 2;
    @(negedge clk);
    send({34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF}, {6'd31, 6'd34}, 2'b11, 0, 0);
    send({34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF}, {6'd31, 6'd34}, 2'b11, 0, 0);
    rdy_mode = 1;
    send({34'h3_FFFF_FFFF, 34'h0}, L68, 2'b11, 1, 0);
    wait_idle("t5");
    chk("t5_count", lg_data.size() - b0, 2);
    chk("t5_beat0", lg_data[b0], {OUT_W{1'b1}});
    chk("t5_beat1", lg_data[b0+1],
        128'h0000_0000_0000_003F_FFFF_FFF0_0000_0003);
    chk("t5_last", lg_last[b0+1], 1);

    // overflow on the 8th beat, one more beat drained
    b0 = lg_data.size();
    for (int i = 0; i < 9; i++)
      send(rcode(), L68, 2'b11, i == 8, 0);
    wait_idle("t6");
    chk("t6_count", lg_data.size() - b0, 4);
    chk("t6_pre_abort", lg_abort[b0+2], 0);
    chk("t6_pre_last", lg_last[b0+2], 0);
    chk("t6_abort", lg_abort[b0+3], 1);
    chk("t6_alast", lg_last[b0+3], 1);
    chk("t6_adata", lg_data[b0+3], 0);

    // exactly LINE_BITS is kept
    b0 = lg_data.size();
    for (int i = 0; i < 8; i++)
      send(rcode(), L64, 2'b11, i == 7, 0);
    wait_idle("t6b");
    chk("t6b_count", lg_data.size() - b0, 4);
    chk("t6b_abort", lg_abort[b0+3], 0);
    chk("t6b_last", lg_last[b0+3], 1);

    // reset in the middle of a line drops everything
    rdy_mode = 2;
    send(rcode(), L68, 2'b11, 0, 0);
    send(rcode(), L68, 2'b11, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("mrst_valid", o_valid, 0);
    chk("mrst_data", o_data, 0);
    @(negedge clk);
    rdy_mode = 0;

    // random lines, random enables, lengths, gaps and backpressure
    for (int ln = 0; ln < 40; ln++) begin
      nb = $urandom_range(1, 24);
      for (int b = 0; b < nb; b++) begin
        c = rcode();
        for (int k = 0; k < LANES; k++) begin
          l[k*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, CODE_W));
          e[k] = ($urandom_range(0, 7) != 0);
        end
        send(c, l, e, b == nb - 1, $urandom_range(0, 2));
      end
      wait_idle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
